// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshakes and a shift-add multiplier
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int SH = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [SH-1:0] LAST = SH'(WIDTH - 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SH-1:0]      cnt_q, cnt_d;

  logic               accept;
  logic [SH-1:0]      amt;
  logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [2*WIDTH-1:0] prod;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign flag_n    = n_q;
  assign flag_v    = v_q;

  // Shifts are done one bit wider so the last bit shifted out lands in the extra bit;
  // with amt=0 that bit is the zero pad, giving flag_c=0 for free.
  assign amt   = b[SH-1:0];
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign shl_w = {1'b0, a} << amt;
  assign shr_w = {a, 1'b0} >> amt;
  assign prod  = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      3'b000: begin
        alu_res = add_w[MSB:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (add_w[MSB] != a[MSB]);
      end
      3'b001: begin
        alu_res = sub_w[MSB:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (sub_w[MSB] != a[MSB]);
      end
      3'b010: alu_res = a & b;
      3'b011: alu_res = a | b;
      3'b100: alu_res = a ^ b;
      3'b101: begin
        alu_res = shl_w[MSB:0];
        alu_c   = shl_w[WIDTH];
      end
      3'b110: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    z_d      = z_q;
    c_d      = c_q;
    n_d      = n_q;
    v_d      = v_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_MUL: begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SH'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          res_d   = prod[MSB:0];
          z_d     = (prod[MSB:0] == '0);
          n_d     = prod[MSB];
          c_d     = |prod[2*WIDTH-1:WIDTH];
          v_d     = 1'b0;
        end
      end
      S_DONE: if (out_ready && !in_valid) state_d = S_IDLE;
      default: ;
    endcase

    // accept is only possible from IDLE or DONE, never mid-multiply
    if (accept) begin
      if (op == 3'b111) begin
        state_d  = S_MUL;
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
        cnt_d    = '0;
      end else begin
        state_d = S_DONE;
        res_d   = alu_res;
        z_d     = (alu_res == '0);
        n_d     = alu_res[MSB];
        c_d     = alu_c;
        v_d     = alu_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      z_q      <= z_d;
      c_q      <= c_d;
      n_q      <= n_d;
      v_q      <= v_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       flag_z, flag_c, flag_n, flag_v;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;

  vec_t vt[13];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_n    (flag_n),
    .flag_v    (flag_v)
  );

  // {out_valid, result, z, c, n, v}
  function automatic logic [12:0] obs();
    return {out_valid, result, flag_z, flag_c, flag_n, flag_v};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_vectors();
    //              op     a      b      result flags zcnv
    vt[0]  = {3'd0, 8'h02, 8'h03, 8'h05, 4'b0000};
    vt[1]  = {3'd0, 8'hFF, 8'h01, 8'h00, 4'b1100};
    vt[2]  = {3'd0, 8'h7F, 8'h01, 8'h80, 4'b0011};
    vt[3]  = {3'd1, 8'h0A, 8'h08, 8'h02, 4'b0000};
    vt[4]  = {3'd1, 8'h08, 8'h0A, 8'hFE, 4'b0110};
    vt[5]  = {3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001};
    vt[6]  = {3'd2, 8'h0A, 8'h0C, 8'h08, 4'b0000};
    vt[7]  = {3'd3, 8'h0A, 8'h0C, 8'h0E, 4'b0000};
    vt[8]  = {3'd4, 8'h0A, 8'h0C, 8'h06, 4'b0000};
    vt[9]  = {3'd5, 8'h81, 8'h01, 8'h02, 4'b0100};
    vt[10] = {3'd6, 8'h81, 8'h09, 8'h40, 4'b0100};
    vt[11] = {3'd5, 8'h81, 8'h08, 8'h81, 4'b0010};
    vt[12] = {3'd6, 8'hC0, 8'h07, 8'h01, 4'b0100};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    step();
    step();
    checks++;
    if (obs() !== 13'h0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset got=%h in_ready=%b exp=%h in_ready=1", obs(), in_ready, 13'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu_ops();
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      op = vt[i].op; a = vt[i].a; b = vt[i].b;
      step();
      in_valid = 1'b0;
      checks++;
      if (obs() !== {1'b1, vt[i].r, vt[i].f}) begin
        failures++;
        $display("FAIL alu_op[%0d] got=%h exp=%h", i, obs(), {1'b1, vt[i].r, vt[i].f});
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL alu_idle[%0d] out_valid got=%b exp=0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op = vt[i].op; a = vt[i].a; b = vt[i].b;
      step();
      checks++;
      if (obs() !== {1'b1, vt[i].r, vt[i].f} || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b[%0d] got=%h in_ready=%b exp=%h in_ready=1", i, obs(), in_ready,
                 {1'b1, vt[i].r, vt[i].f});
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain out_valid got=%b exp=0", out_valid);
    end
  endtask

  task automatic run_mul(input logic [7:0] ma, input logic [7:0] mb, input logic [12:0] exp_o);
    out_ready = 1'b1;
    in_valid = 1'b1; op = 3'd7; a = ma; b = mb;
    step();
    // a competing ADD beat is offered all through the multiply and must be ignored
    op = 3'd0; a = 8'h11; b = 8'h22;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL mul_busy[%0d] out_valid=%b in_ready=%b exp out_valid=0 in_ready=0",
                 k, out_valid, in_ready);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mul_busy[7] out_valid=%b in_ready=%b exp out_valid=0 in_ready=0",
               out_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (obs() !== exp_o) begin
      failures++;
      $display("FAIL mul %h*%h got=%h exp=%h", ma, mb, obs(), exp_o);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mul_idle out_valid got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_mul();
    run_mul(8'h0C, 8'h0B, {1'b1, 8'h84, 4'b0010});
    run_mul(8'h10, 8'h10, {1'b1, 8'h00, 4'b1100});
    run_mul(8'hFF, 8'hFF, {1'b1, 8'h01, 4'b0100});
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd0; a = 8'h7F; b = 8'h01;
    step();
    op = 3'd1; a = 8'h05; b = 8'h03;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (obs() !== {1'b1, 8'h80, 4'b0011} || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=%h in_ready=%b exp=%h in_ready=0",
                 k, obs(), in_ready, {1'b1, 8'h80, 4'b0011});
      end
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (obs() !== {1'b1, 8'h02, 4'b0000}) begin
      failures++;
      $display("FAIL bp_release got=%h exp=%h", obs(), {1'b1, 8'h02, 4'b0000});
    end
    step();
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd1; a = 8'h08; b = 8'h0A;
    step();
    out_ready = 1'b1;
    op = 3'd7; a = 8'h0C; b = 8'h0B;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (obs() !== 13'h0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_mul got=%h in_ready=%b exp=%h in_ready=1", obs(), in_ready, 13'h0);
    end
    rst = 1'b0;
    in_valid = 1'b1; op = 3'd0; a = 8'h02; b = 8'h03;
    step();
    in_valid = 1'b0;
    checks++;
    if (obs() !== {1'b1, 8'h05, 4'b0000}) begin
      failures++;
      $display("FAIL post_reset_add got=%h exp=%h", obs(), {1'b1, 8'h05, 4'b0000});
    end
    step();
  endtask

  task automatic test_reset_in_done();
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd1; a = 8'h08; b = 8'h0A;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (obs() !== 13'h0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_done got=%h in_ready=%b exp=%h in_ready=1", obs(), in_ready, 13'h0);
    end
  endtask

  initial begin
    init_vectors();
    test_reset();
    test_alu_ops();
    test_back_to_back();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_reset_in_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the team's 4-bit combinational ALU. It supports a configurable data width and eight operations, one of which is a multi-cycle shift-add multiply. It uses valid/ready handshakes on both input and output and produces registered status flags. It sits between an operand source, such as a register file or test sequencer, and a result consumer that may apply backpressure.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2. SH = $clog2(WIDTH).
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op beat offered.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result this cycle.
- result  output  WIDTH  registered result.
- flag_z  output  1  result == 0.
- flag_c  output  1  carry / borrow / shifted-out bit / MUL high-half-nonzero.
- flag_n  output  1  result[WIDTH-1].
- flag_v  output  1  signed overflow (ADD/SUB only, else 0).

## Operation
- FSM states: IDLE, MUL, DONE. Reset puts the FSM in IDLE with out_valid=0, result=0, all flags 0, and the multiply counter and accumulators at 0.
- in_ready is 1 in IDLE, 1 in DONE when out_ready=1, and 0 in MUL.
- A beat is accepted when in_valid && in_ready. Operands and op are captured on that edge.
- Non-MUL ops are computed and registered into result/flags on the accept edge. The FSM goes to DONE.
- ADD computes a+b modulo 2^WIDTH. flag_c is the carry out. flag_v = (a[msb]==b[msb]) && (result[msb]!=a[msb]).
- SUB computes a-b modulo 2^WIDTH. flag_c is the borrow, i.e. 1 iff a<b unsigned. flag_v = (a[msb]!=b[msb]) && (result[msb]!=a[msb]).
- AND, OR and XOR are bitwise. flag_c=0 and flag_v=0 for these ops.
- SHL and SHR shift a by amt = b[SH-1:0]; upper bits of b are ignored. Zero fill is used; SHR is logical.
  - flag_c is the last bit shifted out: a[WIDTH-amt] for SHL, a[amt-1] for SHR.
  - When amt=0, flag_c=0 and result=a.
- MUL: on the accept edge the FSM goes to MUL and the 2·WIDTH-bit accumulator is cleared.
  - Each cycle in MUL processes one bit of b, LSB first, for exactly WIDTH cycles.
  - On the final iteration edge the FSM goes to DONE. result = product[WIDTH-1:0] and flag_c = |product[2·WIDTH-1:WIDTH].
- DONE holds result and flags stable while out_ready=0.
  - When out_ready=1 and in_valid=0, the FSM goes to IDLE and out_valid falls.
  - When out_ready=1 and a new beat is accepted on the same edge, the new op starts directly: a non-MUL op reloads result and stays in DONE; MUL goes to MUL.
- flag_z and flag_n are always derived from the registered result, for all ops.
- Only one operation is in flight at a time. There is no queueing.

## Timing
- Non-MUL latency: accepted at edge N gives out_valid=1 after edge N. Throughput is 1 op/cycle when out_ready is held high.
- MUL latency: accepted at edge N gives out_valid=1 after edge N+WIDTH. With WIDTH=8 that is 8 cycles in MUL and 9 edges total including accept.
- out_valid is 0 throughout MUL.
- Reset asserted in any state, including mid-MUL or DONE with pending backpressure, returns to reset values on that edge. The partial product is discarded. rst has priority over the handshake.
- in_valid while in_ready=0 is ignored. The source must hold the beat until it is accepted.
- Outputs are purely registered. in_ready is combinational from state and out_ready only.

## Test plan
- ADD with WIDTH=8: 0x02+0x03 -> result=0x05, z=0 c=0 n=0 v=0. Then 0xFF+0x01 -> 0x00, z=1 c=1. Then 0x7F+0x01 -> 0x80, n=1 v=1. Back-to-back with out_ready=1 must give one result per cycle.
- SUB: 0x0A-0x08 -> 0x02 c=0. Then 0x08-0x0A -> 0xFE c=1 n=1. Then 0x80-0x01 -> 0x7F v=1.
- Logic and shift: AND 0x0A,0x0C -> 0x08; OR -> 0x0E; XOR -> 0x06; SHL 0x81 by 1 -> 0x02 c=1; SHR 0x81 by 0x09 (amt=1) -> 0x40 c=1.
- MUL: 0x0C×0x0B -> 0x84 c=0, out_valid exactly 8 edges after accept, and in_ready=0 meanwhile. Then 0x10×0x10 -> 0x00 z=1 c=1.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD result. result, flags and out_valid must stay stable and in_ready must be 0. Raising out_ready together with a new beat must accept it on the same edge.
- Reset: assert rst at cycle 4 of a MUL -> next cycle out_valid=0, result=0, flags=0, in_ready=1. A subsequent ADD must complete normally.
